alu_result_stage: RTL and testbench

- Pipeline register stage directly downstream of the ALU logical/arithmetic units (AND/OR/XOR/adder).
- Captures each ALU result with its destination tag and opcode, computes the zero and negative flags, and presents them to writeback over a valid/ready handshake.
- Contains a 2-entry skid buffer so the ALU side never sees a combinational ready path from writeback.

---
 rtl/alu_result_stage.sv | 125 ++++++++++++
 tb/tb_alu_result_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result pipeline register with a 2-entry skid buffer toward writeback.
// Define ALU_RETIRE_CNT_EN to add the 32-bit retire_count output.
module alu_result_stage #(
  parameter int WIDTH  = 64,
  parameter int DEST_W = 5,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic [OP_W-1:0]   out_op,
  output logic              out_zero,
  output logic              out_neg
`ifdef ALU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [DEST_W-1:0] dest;
    logic [OP_W-1:0]   op;
    logic              zero;
    logic              neg;
  } entry_t;

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e state, state_n;
  entry_t main_q, skid_q, in_entry;
  logic   main_valid, skid_valid;
  logic   accept, fire;
  logic   load_in_main, load_in_skid, load_skid_main;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_ready   = !skid_valid & !rst;
  assign out_valid  = main_valid;
  assign accept     = in_valid & in_ready;
  assign fire       = main_valid & out_ready;

  assign in_entry = '{
    result: in_result,
    dest:   in_dest,
    op:     in_op,
    zero:   ~|in_result,
    neg:    in_result[WIDTH-1]
  };

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    load_in_main   = 1'b0;
    load_in_skid   = 1'b0;
    load_skid_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_in_main = 1'b1;
          state_n      = ONE;
        end
      end
      ONE: begin
        if (accept && fire) begin
          load_in_main = 1'b1;
        end else if (accept) begin
          load_in_skid = 1'b1;
          state_n      = FULL;
        end else if (fire) begin
          state_n      = EMPTY;
        end
      end
      FULL: begin
        if (fire) begin
          load_skid_main = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_in_main)        main_q <= in_entry;
      else if (load_skid_main) main_q <= skid_q;
      if (load_in_skid)        skid_q <= in_entry;
    end
  end

  assign out_result = main_q.result;
  assign out_dest   = main_q.dest;
  assign out_op     = main_q.op;
  assign out_zero   = main_q.zero;
  assign out_neg    = main_q.neg;

`ifdef ALU_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       retire_count <= '0;
    else if (fire) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: FIFO reference model plus directed
// and random traffic; ALU_RETIRE_CNT_EN also exercises retire_count.
module tb_alu_result_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_result, out_result;
  logic [4:0]  in_dest, out_dest;
  logic [3:0]  in_op, out_op;
  logic        out_zero, out_neg;
`ifdef ALU_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  alu_result_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dest(in_dest), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg)
`ifdef ALU_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct {
    logic [63:0] r;
    logic [4:0]  d;
    logic [3:0]  o;
    logic        z;
    logic        n;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          fires = 0;
  int          cycles = 0;
  logic [31:0] cnt_exp = 0;
  bit          rand_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [63:0] r, input logic [4:0] d,
                                 input logic [3:0] o);
    exp_t e;
    e.r = r;
    e.d = d;
    e.o = o;
    e.z = (r == 64'd0);
    e.n = ($signed(r) < 0);
    return e;
  endfunction

  // Monitor: mid-cycle view of what the next rising edge will do.
  always @(negedge clk) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, !rst && q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    if (out_valid && q.size() != 0) begin
      chk("out_result", out_result, q[0].r);
      chk("out_dest", {59'd0, out_dest}, {59'd0, q[0].d});
      chk("out_op", {60'd0, out_op}, {60'd0, q[0].o});
      chk("out_zero", {63'd0, out_zero}, {63'd0, q[0].z});
      chk("out_neg", {63'd0, out_neg}, {63'd0, q[0].n});
    end
`ifdef ALU_RETIRE_CNT_EN
    chk("retire_count", {32'd0, retire_count}, {32'd0, cnt_exp});
`endif
    if (rst) begin
      q.delete();
      cnt_exp = 0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        fires++;
        cnt_exp = cnt_exp + 1;
      end
      if (in_valid && in_ready)
        q.push_back(model(in_result, in_dest, in_op));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic offer(input logic [63:0] r, input logic [4:0] d,
                       input logic [3:0] o);
    bit got = 0;
    in_valid  = 1'b1;
    in_result = r;
    in_dest   = d;
    in_op     = o;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      nvec++;
      nfail++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = 64'd0;
      1:       v = {1'b1, 31'($urandom), 32'($urandom)};
      2:       v = 64'd1 << $urandom_range(0, 63);
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] a, b;
    int f0, c0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_result = '0;
    in_dest = '0;
    in_op = '0;
    out_ready = 1'b0;
    idle(2);
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_out_neg", {63'd0, out_neg}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    a = 64'hAAAAAAAAAAAAAAAA;
    b = 64'h5555555555555555;
    offer(a & b, 5'd3, 4'd1);
    @(negedge clk);
    chk("and_valid", {63'd0, out_valid}, 64'd1);
    chk("and_result", out_result, 64'd0);
    chk("and_zero", {63'd0, out_zero}, 64'd1);
    chk("and_neg", {63'd0, out_neg}, 64'd0);
    chk("and_dest", {59'd0, out_dest}, 64'd3);
    @(posedge clk);
    #1;

    offer(a, 5'd4, 4'd2);
    @(negedge clk);
    chk("neg_zero", {63'd0, out_zero}, 64'd0);
    chk("neg_neg", {63'd0, out_neg}, 64'd1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    f0 = fires;
    offer(64'h1111, 5'd5, 4'd3);
    offer(64'h2222, 5'd6, 4'd4);
    @(negedge clk);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    fork
      offer(64'h3333, 5'd7, 4'd5);
      begin
        idle(3);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_fires", fires - f0, 3);

    f0 = fires;
    c0 = cycles;
    for (int i = 0; i < 10; i++)
      offer(64'h100 + 64'(i), 5'(i), 4'(i));
    chk("stream_cycles", cycles - c0, 10);
    idle(1);
    chk("stream_fires", fires - f0, 10);

    out_ready = 1'b0;
    offer(64'hDEAD, 5'd9, 4'd9);
    offer(64'hBEEF, 5'd10, 4'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_full_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_full_ready1", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(3);

    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          else offer(rand_val(), 5'($urandom), 4'($urandom));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    idle(4);
    chk("drained", {63'd0, out_valid}, 64'd0);

`ifdef ALU_RETIRE_CNT_EN
    force dut.retire_count = 32'hFFFFFFFE;
    #1;
    release dut.retire_count;
    cnt_exp = 32'hFFFFFFFE;
    offer(64'h5, 5'd1, 4'd1);
    offer(64'h6, 5'd2, 4'd2);
    @(negedge clk);
    chk("cnt_max", {32'd0, retire_count}, 64'hFFFFFFFF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cnt_wrap", {32'd0, retire_count}, 64'd0);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
